// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-requester arbiter in front of a single-port data memory;
//            each access takes one ACCESS cycle. Define DMEM_ARB_RR_EN for
//            round-robin tie-breaking (default: fixed priority, port 0 wins).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              gnt_0,
  output logic              rvalid_0,
  output logic [DATA_W-1:0] rdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_1,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              busy
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  logic              we_q;
  logic              owner_q;
  logic              win;
  logic              accept;
  logic              rd_done;

  assign accept  = (state == S_IDLE) && (req_0 || req_1);
  assign rd_done = (state == S_ACCESS) && !we_q;

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  // On a tie the port that did not win last time goes first.
  always_comb win = (req_0 && req_1) ? ~last_q : req_1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_q <= 1'b1;
    else if (accept) last_q <= win;
  end
`else
  always_comb win = ~req_0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_0 || req_1) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic; mem_we is gated by state so reset kills a write at once.
  always_comb begin
    busy   = (state == S_ACCESS);
    mem_we = (state == S_ACCESS) && we_q;
    mem_a  = addr_q;
    mem_wd = wd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      owner_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= win ? addr_1  : addr_0;
      wd_q    <= win ? wdata_1 : wdata_0;
      we_q    <= win ? we_1    : we_0;
      owner_q <= win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_0    <= 1'b0;
      gnt_1    <= 1'b0;
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      rdata_0  <= '0;
      rdata_1  <= '0;
    end else begin
      gnt_0    <= accept && !win;
      gnt_1    <= accept && win;
      rvalid_0 <= rd_done && !owner_q;
      rvalid_1 <= rd_done && owner_q;
      if (rd_done && !owner_q) rdata_0 <= mem_rd;
      if (rd_done && owner_q)  rdata_1 <= mem_rd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// Testbench for dmem_arbiter: directed stimulus, expected grant/read events
// queued by the driver and consumed by an independent monitor.
module tb_dmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_0 = 1'b0, we_0 = 1'b0, req_1 = 1'b0, we_1 = 1'b0;
  logic [AW-1:0] addr_0 = '0, addr_1 = '0;
  logic [DW-1:0] wdata_0 = '0, wdata_1 = '0;
  logic          gnt_0, gnt_1, rvalid_0, rvalid_1, mem_we, busy;
  logic [DW-1:0] rdata_0, rdata_1, mem_wd, mem_rd;
  logic [AW-1:0] mem_a;

  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [DW-1:0] pl_d = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  typedef struct packed {
    logic          rv;
    logic          port;
    logic [DW-1:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write commits on the clock edge.
  assign mem_rd = mem[mem_a];
  always @(posedge clk) begin
    if (pl_en)       mem[pl_a]  <= pl_d;
    else if (mem_we) mem[mem_a] <= mem_wd;
  end

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  function automatic void sb_pop(logic rv, logic port, logic [DW-1:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual=%s port%0d required=none",
               rv ? "rvalid" : "gnt", port);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind", 32'(rv), 32'(e.rv));
      chk("sb_port", 32'(port), 32'(e.port));
      if (rv) chk("sb_rdata", data, e.data);
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt_0 && gnt_1) begin
        checks++; failures++;
        $display("FAIL dual_gnt actual=both required=one");
      end else if (gnt_0 || gnt_1) begin
        sb_pop(1'b0, gnt_1, '0);
      end
      if (rvalid_0 && rvalid_1) begin
        checks++; failures++;
        $display("FAIL dual_rvalid actual=both required=one");
      end else if (rvalid_0 || rvalid_1) begin
        sb_pop(1'b1, rvalid_1, rvalid_1 ? rdata_1 : rdata_0);
      end
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_a = a; pl_d = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic set_req(input logic port, input logic r, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (port) begin req_1 = r; we_1 = we; addr_1 = a; wdata_1 = wd; end
    else      begin req_0 = r; we_0 = we; addr_0 = a; wdata_0 = wd; end
  endtask

  // Single access issued from IDLE; called and returns on a falling edge.
  task automatic do_req(input logic port, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    exp_q.push_back('{rv: 1'b0, port: port, data: '0});
    if (!we) exp_q.push_back('{rv: 1'b1, port: port, data: exp_rd});
    set_req(port, 1'b1, we, a, wd);
    @(negedge clk);
    chk("gnt_first_edge", 32'(port ? gnt_1 : gnt_0), 32'd1);
    chk("busy_access", 32'(busy), 32'd1);
    chk("mem_we_access", 32'(mem_we), 32'(we));
    chk("mem_a_access", 32'(mem_a), 32'(a));
    if (port) req_1 = 1'b0; else req_0 = 1'b0;
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    chk("mem_we_after", 32'(mem_we), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic p;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt_0 | gnt_1), 32'd0);
    chk("rst_rvalid", 32'(rvalid_0 | rvalid_1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_a", 32'(mem_a), 32'd0);
    chk("rst_rdata0", rdata_0, 32'd0);
    chk("rst_rdata1", rdata_1, 32'd0);

    preload(12'd10, 32'd100);
    preload(12'd5,  32'd0);
    preload(12'd7,  32'h77);
    preload(12'd20, 32'd111);
    preload(12'd21, 32'd222);
    rst_n = 1'b1;

    // Single read straight after reset release
    do_req(1'b0, 1'b0, 12'd10, 32'd0, 32'd100);
    chk("rdata0_single", rdata_0, 32'd100);

    // Write then read on port 1
    do_req(1'b1, 1'b1, 12'd5, 32'hDEADBEEF, 32'd0);
    chk("mem5_written", mem[5], 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 12'd5, 32'd0, 32'hDEADBEEF);
    chk("rdata1_readback", rdata_1, 32'hDEADBEEF);
    chk("rdata0_hold", rdata_0, 32'd100);

    // Contention: both ports held for 8 edges
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      p = (i % 2 == 1);
`else
      p = 1'b0;
`endif
      exp_q.push_back('{rv: 1'b0, port: p, data: '0});
      exp_q.push_back('{rv: 1'b1, port: p, data: p ? 32'd222 : 32'd111});
    end
    set_req(1'b0, 1'b1, 1'b0, 12'd20, 32'd0);
    set_req(1'b1, 1'b1, 1'b0, 12'd21, 32'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    req_0 = 1'b0;
    req_1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("contention_drain", 32'(exp_q.size()), 32'd0);

    // Reset during the ACCESS cycle of a write
    set_req(1'b0, 1'b1, 1'b1, 12'd7, 32'h12345678);
    @(posedge clk);
    #1;
    chk("midwr_we_pre", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midwr_we_rst", 32'(mem_we), 32'd0);
    chk("midwr_gnt_rst", 32'(gnt_0 | gnt_1), 32'd0);
    chk("midwr_busy_rst", 32'(busy), 32'd0);
    req_0 = 1'b0;
    we_0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midwr_rvalid", 32'(rvalid_0 | rvalid_1), 32'd0);
    chk("mem7_kept", mem[7], 32'h77);
    rst_n = 1'b1;
    do_req(1'b0, 1'b0, 12'd7, 32'd0, 32'h77);
    chk("rdata0_post_rst", rdata_0, 32'h77);

    // Idle stability
    repeat (10) begin
      @(negedge clk);
      chk("idle_mem_we", 32'(mem_we), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_mem_a", 32'(mem_a), 32'd7);
    end
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
